turfio_bidir_sched: RTL and testbench
=====================================

TURFIO_BIDIR_SCHED -- requirements
Module: turfio_bidir_sched

Interface
REQ-001 SHALL have parameter NBITS, default 32, command/response payload width in bits.
REQ-002 SHALL have parameter TURN_CLKS, default 128, turnaround hold time in rxclk_i cycles, power of two, 2..256.
REQ-003 SHALL have port rxclk_i  in  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_bit_i  in  1  registered line sample from the IOB input flop.
REQ-006 SHALL have port tx_bit_o  out  1  line data to the IOB output flop, non-inverted.
REQ-007 SHALL have port tx_tri_o  out  1  IOB T input: 1 = tristate, 0 = drive.
REQ-008 SHALL have port cmd_data_o  out  NBITS  last received command, MSB first on the line.
REQ-009 SHALL have port cmd_valid_o  out  1  one-cycle pulse when cmd_data_o updates.
REQ-010 SHALL have port pre_err_o  out  1  one-cycle pulse on a preamble mismatch.
REQ-011 SHALL have port req_i  in  2  response requests, level, one bit per requester.
REQ-012 SHALL have port resp0_i and resp1_i  in  NBITS each  response words, held stable while the matching req_i bit is high.
REQ-013 SHALL have port ack_o  out  2  one-cycle pulse on the granted bit after its last response bit is driven.

Function
REQ-014 SHALL implement states IDLE, PRE0, PRE1, PRE2, DATA, TURN_IN, POST, RESP, TURN_OUT.
REQ-015 IDLE: SHALL go to PRE0 on a falling edge, i.e. rx_bit_i=0 with the previous sample 1.
REQ-016 PRE0/PRE1/PRE2: SHALL require rx_bit_i = 1, 0, 1 on successive cycles; any mismatch SHALL return to IDLE and pulse pre_err_o.
REQ-017 DATA: SHALL shift NBITS samples MSB first, then update cmd_data_o and pulse cmd_valid_o in the cycle after the last bit.
REQ-018 At DATA exit: req_i==0 SHALL go to IDLE with no turnaround; otherwise SHALL latch the grant and response word and go to TURN_IN.
REQ-019 Arbitration SHALL be round-robin: both requesting grants the bit not granted last time; the pointer updates only on grant; the pointer resets to favour bit 0.
REQ-020 TURN_IN: SHALL keep tx_tri_o=1 for TURN_CLKS cycles, then go to POST.
REQ-021 POST: SHALL drive 1,1,1,0 over 4 cycles with tx_tri_o=0.
REQ-022 RESP: SHALL drive the latched word MSB first over NBITS cycles; ack_o SHALL pulse in the cycle after the last bit.
REQ-023 TURN_OUT: SHALL drive 1 for TURN_CLKS cycles, set tx_tri_o=1 in the last cycle, then go to IDLE.
REQ-024 tx_tri_o SHALL be 0 only in POST, RESP and TURN_OUT.
REQ-025 tx_bit_o SHALL be 1 whenever tx_tri_o=1.
REQ-026 rx_bit_i SHALL be ignored from TURN_IN through TURN_OUT.
REQ-027 Deasserting req_i after the grant SHALL NOT alter the response in flight.
REQ-028 The bit counter SHALL be clog2(NBITS)+1 bits wide; the turnaround counter SHALL be clog2(TURN_CLKS)+1 bits wide.
REQ-029 Both counters SHALL clear on every state entry.

Reset
REQ-030 On rst_i, the next edge SHALL set: state=IDLE, tx_tri_o=1, tx_bit_o=1, cmd_data_o=0, cmd_valid_o=0, pre_err_o=0, ack_o=0, RR pointer=0, edge register=1.
REQ-031 Reset asserted mid-RESP or mid-TURN_OUT SHALL release the line on the next edge with no ack_o pulse.

Structure
REQ-032 A shared package turfio_bidir_pkg SHALL hold the state enum and constants PREAMBLE=5'b10101 and POSTAMBLE=4'b1110.
REQ-033 The arbiter SHALL be a sub-module turfio_rr_arb2: req[1:0], grant enable, one-hot grant out, pointer register.

Verification
REQ-034 Frame 10101 + 0xDEADBEEF with req_i=00 -> cmd_data_o=0xDEADBEEF, one cmd_valid_o pulse, tx_tri_o stays 1.
REQ-035 Frame with req_i=01 and resp0_i=0x12345678 -> 128 cycles tristate, then line 1110, then 0x12345678 MSB first, 128 ones, ack_o=01 once, then tristate.
REQ-036 Three frames with req_i=11 throughout -> grants 01, 10, 01 in order.
REQ-037 Line pattern 1,0,1,1 (PRE1 mismatch) -> one pre_err_o pulse, state returns to IDLE, no cmd_valid_o pulse.
REQ-038 rst_i pulsed 10 cycles into RESP -> tx_tri_o=1 and tx_bit_o=1 on the next edge, no ack_o, next frame decoded normally.
REQ-039 NBITS=8, TURN_CLKS=4 -> same sequencing with scaled lengths, all counters correct at the boundaries.

Source files
------------

// File: rtl/turfio_bidir_pkg.sv
// Shared types and line constants for the TURFIO bidirectional command/response scheduler.
package turfio_bidir_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PRE0,
    PRE1,
    PRE2,
    DATA,
    TURN_IN,
    POST,
    RESP,
    TURN_OUT
  } state_t;

  localparam logic [4:0] PREAMBLE  = 5'b10101;
  localparam logic [3:0] POSTAMBLE = 4'b1110;

endpackage

// File: rtl/turfio_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer only moves when a grant is taken.
module turfio_rr_arb2 (
  input  logic       rxclk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       gnt_en_i,
  output logic [1:0] grant_o
);

  logic ptr;

  always_comb begin
    grant_o = 2'b00;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  // ptr=1 favours bit 1, so granting bit 0 hands priority to bit 1 and vice versa
  always_ff @(posedge rxclk_i) begin
    if (rst_i) begin
      ptr <= 1'b0;
    end else if (gnt_en_i && (grant_o != 2'b00)) begin
      ptr <= grant_o[0];
    end
  end

endmodule

// File: rtl/turfio_bidir_sched.sv
// Half-duplex line scheduler: decodes preamble+command, then optionally turns the line
// around and drives postamble+response for the round-robin selected requester.
module turfio_bidir_sched
  import turfio_bidir_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int TURN_CLKS = 128
) (
  input  logic             rxclk_i,
  input  logic             rst_i,
  input  logic             rx_bit_i,
  output logic             tx_bit_o,
  output logic             tx_tri_o,
  output logic [NBITS-1:0] cmd_data_o,
  output logic             cmd_valid_o,
  output logic             pre_err_o,
  input  logic [1:0]       req_i,
  input  logic [NBITS-1:0] resp0_i,
  input  logic [NBITS-1:0] resp1_i,
  output logic [1:0]       ack_o
);

  localparam int BCW = $clog2(NBITS) + 1;
  localparam int TCW = $clog2(TURN_CLKS) + 1;
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(NBITS - 1);
  localparam logic [BCW-1:0] POST_LAST = BCW'(3);
  localparam logic [TCW-1:0] TURN_LAST = TCW'(TURN_CLKS - 1);
  localparam logic [TCW-1:0] TURN_REL  = TCW'(TURN_CLKS - 2);

  state_t           state;
  logic [BCW-1:0]   bit_cnt;
  logic [TCW-1:0]   turn_cnt;
  logic             edge_q;
  logic [1:0]       grant;
  logic [1:0]       grant_q;
  logic [NBITS-1:0] rx_sr;
  logic [NBITS-1:0] resp_sr;
  logic             last_data;
  logic             gnt_en;

  assign last_data = (state == DATA) && (bit_cnt == BIT_LAST);
  assign gnt_en    = last_data && (req_i != 2'b00);

  turfio_rr_arb2 u_arb (
    .rxclk_i  (rxclk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .gnt_en_i (gnt_en),
    .grant_o  (grant)
  );

  // Datapath shift registers carry no reset; the FSM decides when they matter.
  always_ff @(posedge rxclk_i) begin
    if (state == DATA) begin
      rx_sr <= {rx_sr[NBITS-2:0], rx_bit_i};
    end
    if (gnt_en) begin
      resp_sr <= grant[1] ? resp1_i : resp0_i;
    end else if (((state == POST) && (bit_cnt == POST_LAST)) || (state == RESP)) begin
      resp_sr <= {resp_sr[NBITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge rxclk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      turn_cnt    <= '0;
      edge_q      <= 1'b1;
      tx_tri_o    <= 1'b1;
      tx_bit_o    <= 1'b1;
      cmd_data_o  <= '0;
      cmd_valid_o <= 1'b0;
      pre_err_o   <= 1'b0;
      ack_o       <= 2'b00;
      grant_q     <= 2'b00;
    end else begin
      cmd_valid_o <= 1'b0;
      pre_err_o   <= 1'b0;
      ack_o       <= 2'b00;
      bit_cnt     <= bit_cnt + 1'b1;
      turn_cnt    <= turn_cnt + 1'b1;
      // The edge register only follows the line while we are listening.
      if (state inside {IDLE, PRE0, PRE1, PRE2, DATA}) begin
        edge_q <= rx_bit_i;
      end

      unique case (state)
        IDLE: begin
          if (edge_q && !rx_bit_i) begin
            state <= PRE0; bit_cnt <= '0; turn_cnt <= '0;
          end
        end
        PRE0, PRE1, PRE2: begin
          bit_cnt  <= '0;
          turn_cnt <= '0;
          if (rx_bit_i != PREAMBLE[2'(PRE2 - state)]) begin
            state     <= IDLE;
            pre_err_o <= 1'b1;
          end else begin
            state <= (state == PRE0) ? PRE1 : (state == PRE1) ? PRE2 : DATA;
          end
        end
        DATA: begin
          if (last_data) begin
            cmd_data_o  <= {rx_sr[NBITS-2:0], rx_bit_i};
            cmd_valid_o <= 1'b1;
            bit_cnt     <= '0;
            turn_cnt    <= '0;
            if (req_i == 2'b00) begin
              state <= IDLE;
            end else begin
              grant_q <= grant;
              state   <= TURN_IN;
            end
          end
        end
        TURN_IN: begin
          if (turn_cnt == TURN_LAST) begin
            state <= POST; bit_cnt <= '0; turn_cnt <= '0;
            tx_tri_o <= 1'b0;
            tx_bit_o <= POSTAMBLE[3];
          end
        end
        POST: begin
          if (bit_cnt == POST_LAST) begin
            state <= RESP; bit_cnt <= '0; turn_cnt <= '0;
            tx_bit_o <= resp_sr[NBITS-1];
          end else begin
            tx_bit_o <= POSTAMBLE[2'd2 - bit_cnt[1:0]];
          end
        end
        RESP: begin
          if (bit_cnt == BIT_LAST) begin
            state <= TURN_OUT; bit_cnt <= '0; turn_cnt <= '0;
            tx_bit_o <= 1'b1;
            ack_o    <= grant_q;
          end else begin
            tx_bit_o <= resp_sr[NBITS-1];
          end
        end
        TURN_OUT: begin
          if (turn_cnt == TURN_REL) begin
            tx_tri_o <= 1'b1;
          end
          if (turn_cnt == TURN_LAST) begin
            state <= IDLE; bit_cnt <= '0; turn_cnt <= '0;
            edge_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE; bit_cnt <= '0; turn_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_turfio_bidir_sched.sv
// Directed bench for turfio_bidir_sched: full-size instance plus a scaled NBITS=8/TURN_CLKS=4 instance.
module tb_turfio_bidir_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  bit          sel = 1'b0;
  int          passed = 0;
  int          fails = 0;
  int          total = 0;

  logic        rx = 1'b1;
  logic        tx_bit, tx_tri, cmd_valid, pre_err;
  logic [31:0] cmd_data;
  logic [1:0]  req = 2'b00;
  logic [31:0] resp0 = '0, resp1 = '0;
  logic [1:0]  ack;

  logic        rx8 = 1'b1;
  logic        tx_bit8, tx_tri8, cmd_valid8, pre_err8;
  logic [7:0]  cmd_data8;
  logic [1:0]  req8 = 2'b00;
  logic [7:0]  resp0_8 = '0, resp1_8 = '0;
  logic [1:0]  ack8;

  always #5 clk = ~clk;

  turfio_bidir_sched dut (
    .rxclk_i(clk), .rst_i(rst), .rx_bit_i(rx), .tx_bit_o(tx_bit), .tx_tri_o(tx_tri),
    .cmd_data_o(cmd_data), .cmd_valid_o(cmd_valid), .pre_err_o(pre_err),
    .req_i(req), .resp0_i(resp0), .resp1_i(resp1), .ack_o(ack)
  );

  turfio_bidir_sched #(.NBITS(8), .TURN_CLKS(4)) dut8 (
    .rxclk_i(clk), .rst_i(rst), .rx_bit_i(rx8), .tx_bit_o(tx_bit8), .tx_tri_o(tx_tri8),
    .cmd_data_o(cmd_data8), .cmd_valid_o(cmd_valid8), .pre_err_o(pre_err8),
    .req_i(req8), .resp0_i(resp0_8), .resp1_i(resp1_8), .ack_o(ack8)
  );

  function automatic logic o_tri();          return sel ? tx_tri8 : tx_tri;       endfunction
  function automatic logic o_bit();          return sel ? tx_bit8 : tx_bit;       endfunction
  function automatic logic o_valid();        return sel ? cmd_valid8 : cmd_valid; endfunction
  function automatic logic o_err();          return sel ? pre_err8 : pre_err;     endfunction
  function automatic logic [1:0] o_ack();    return sel ? ack8 : ack;             endfunction
  function automatic logic [63:0] o_data();  return sel ? 64'(cmd_data8) : 64'(cmd_data); endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one line sample, let the DUT take it, then look just after the edge.
  task automatic step(input logic b);
    if (sel) rx8 = b; else rx = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [63:0] word, input int nb);
    step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
    for (int i = nb - 1; i >= 0; i--) step(word[i]);
  endtask

  task automatic frame_chk(input string tag, input logic [63:0] word);
    chk({tag, "_valid"}, o_valid(), 1'b1);
    chk({tag, "_data"}, o_data(), word);
  endtask

  task automatic line_seg(input string tag, input int n, input logic rxv,
                          input logic etri, input logic ebit);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      step(rxv);
      if (o_tri() !== etri || o_bit() !== ebit || o_ack() !== 2'b00 || o_valid() !== 1'b0)
        bad++;
    end
    chk({tag, "_badcycles"}, bad, 0);
  endtask

  task automatic resp_seg(input string tag, input logic [63:0] word, input int nb, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b0);
      if (o_tri() !== 1'b0 || o_bit() !== word[nb-1-i] || o_ack() !== 2'b00) bad++;
    end
    chk({tag, "_badcycles"}, bad, 0);
  endtask

  task automatic full_resp(input string tag, input logic [63:0] word, input logic [1:0] eack,
                           input int nb, input int tc);
    chk({tag, "_turn_in0_tri"}, o_tri(), 1'b1);
    line_seg({tag, "_turn_in"}, tc - 1, 1'b0, 1'b1, 1'b1);
    line_seg({tag, "_post_ones"}, 3, 1'b0, 1'b0, 1'b1);
    line_seg({tag, "_post_zero"}, 1, 1'b0, 1'b0, 1'b0);
    resp_seg({tag, "_resp"}, word, nb, nb);
    step(1'b0);
    chk({tag, "_ack"}, o_ack(), eack);
    chk({tag, "_ack_line"}, {o_tri(), o_bit()}, 2'b01);
    line_seg({tag, "_turn_out"}, tc - 2, 1'b0, 1'b0, 1'b1);
    line_seg({tag, "_turn_out_last"}, 1, 1'b0, 1'b1, 1'b1);
    line_seg({tag, "_idle"}, 3, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    // Reset values
    rst = 1'b1;
    step(1'b1); step(1'b1);
    chk("rst_tri", tx_tri, 1'b1);
    chk("rst_bit", tx_bit, 1'b1);
    chk("rst_data", cmd_data, 32'h0);
    chk("rst_valid_err", {cmd_valid, pre_err}, 2'b00);
    chk("rst_ack", ack, 2'b00);
    chk("rst8_line", {tx_tri8, tx_bit8, ack8}, 4'b1100);
    rst = 1'b0;
    step(1'b1);

    // Command only, no requester: no turnaround
    req = 2'b00;
    send_frame(64'hDEADBEEF, 32);
    frame_chk("cmd_only", 64'hDEADBEEF);
    chk("cmd_only_tri", tx_tri, 1'b1);
    line_seg("cmd_only_after", 20, 1'b1, 1'b1, 1'b1);

    // Single requester, request dropped right after the grant
    req = 2'b01; resp0 = 32'h12345678; resp1 = 32'hFFFF0000;
    send_frame(64'h0F1E2D3C, 32);
    frame_chk("r0_cmd", 64'h0F1E2D3C);
    req = 2'b00; resp0 = 32'h0;
    full_resp("r0", 64'h12345678, 2'b01, 32, 128);

    // Preamble mismatch in PRE1 (line 1,0,1,1)
    step(1'b1); step(1'b0); step(1'b1); step(1'b1);
    chk("pre1_err", pre_err, 1'b1);
    step(1'b1);
    chk("pre1_err_once", pre_err, 1'b0);
    line_seg("pre1_idle", 40, 1'b1, 1'b1, 1'b1);

    // Preamble mismatch in PRE2 (line 1,0,1,0,0)
    step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b0);
    chk("pre2_err", pre_err, 1'b1);
    line_seg("pre2_idle", 40, 1'b1, 1'b1, 1'b1);

    // Reset ten cycles into RESP releases the line with no ack
    req = 2'b01; resp0 = 32'hCAFEF00D;
    send_frame(64'h00C0FFEE, 32);
    frame_chk("rstresp_cmd", 64'h00C0FFEE);
    line_seg("rstresp_turn_in", 127, 1'b0, 1'b1, 1'b1);
    line_seg("rstresp_post_ones", 3, 1'b0, 1'b0, 1'b1);
    line_seg("rstresp_post_zero", 1, 1'b0, 1'b0, 1'b0);
    resp_seg("rstresp_resp", 64'hCAFEF00D, 32, 10);
    rst = 1'b1;
    step(1'b1);
    chk("rstresp_line", {tx_tri, tx_bit}, 2'b11);
    chk("rstresp_ack", ack, 2'b00);
    rst = 1'b0;
    req = 2'b00;
    line_seg("rstresp_idle", 40, 1'b1, 1'b1, 1'b1);
    send_frame(64'h0BADCAFE, 32);
    frame_chk("rstresp_next", 64'h0BADCAFE);
    line_seg("rstresp_next_idle", 5, 1'b1, 1'b1, 1'b1);

    // Both requesting for three frames: 01, 10, 01
    req = 2'b11; resp0 = 32'hAAAA5555; resp1 = 32'h3C3CC3C3;
    send_frame(64'h11111111, 32);
    frame_chk("rr1_cmd", 64'h11111111);
    full_resp("rr1", 64'hAAAA5555, 2'b01, 32, 128);
    send_frame(64'h22222222, 32);
    frame_chk("rr2_cmd", 64'h22222222);
    full_resp("rr2", 64'h3C3CC3C3, 2'b10, 32, 128);
    send_frame(64'h33333333, 32);
    frame_chk("rr3_cmd", 64'h33333333);
    full_resp("rr3", 64'hAAAA5555, 2'b01, 32, 128);
    req = 2'b00;

    // Scaled instance NBITS=8, TURN_CLKS=4
    sel = 1'b1;
    req8 = 2'b01; resp0_8 = 8'hC3; resp1_8 = 8'h5A;
    send_frame(64'h96, 8);
    frame_chk("s0_cmd", 64'h96);
    full_resp("s0", 64'hC3, 2'b01, 8, 4);
    req8 = 2'b11;
    send_frame(64'h69, 8);
    frame_chk("s1_cmd", 64'h69);
    full_resp("s1", 64'h5A, 2'b10, 8, 4);
    req8 = 2'b00;
    send_frame(64'hF0, 8);
    frame_chk("s2_cmd", 64'hF0);
    chk("s2_tri", o_tri(), 1'b1);
    line_seg("s2_idle", 8, 1'b1, 1'b1, 1'b1);
    step(1'b1); step(1'b0); step(1'b0);
    chk("s_pre0_err", o_err(), 1'b1);
    line_seg("s_pre0_idle", 6, 1'b1, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
